// File: rtl/alu_pkg.sv
// Shared definitions for the ALU function-unit slice: widths, opcode
// encodings and the dispatcher state type.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int RES_W  = 16;
  localparam int OP_W   = 3;

  localparam logic [OP_W-1:0] ALU_ADD = 3'd0;
  localparam logic [OP_W-1:0] ALU_SUB = 3'd1;
  localparam logic [OP_W-1:0] ALU_MUL = 3'd2;
  localparam logic [OP_W-1:0] ALU_DIV = 3'd3;
  localparam logic [OP_W-1:0] ALU_AND = 3'd4;
  localparam logic [OP_W-1:0] ALU_OR  = 3'd5;
  localparam logic [OP_W-1:0] ALU_XOR = 3'd6;
  localparam logic [OP_W-1:0] ALU_NOT = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } disp_state_t;

  // An opcode addresses a unit only if that unit index is populated.
  function automatic logic op_in_range(input logic [OP_W-1:0] op, input int num_units);
    return int'(op) < num_units;
  endfunction

endpackage

// File: rtl/alu_watchdog.sv
// Wait-cycle counter for the dispatcher. expired rises once the counter has
// seen TIMEOUT enabled cycles since the last clear; it then holds.
module alu_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // The cycle in which count equals LAST is the TIMEOUT-th waited cycle.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/alu_dispatch.sv
// Request-side controller for the shared start/done ALU units: issues one
// operation at a time, waits for the selected unit's done, returns the result.
module alu_dispatch
  import alu_pkg::*;
#(
  parameter int NUM_UNITS = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  // Both ports: a transfer happens in a cycle where valid and ready are both
  // high; valid never depends on ready, and payload holds while valid waits.
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [OP_W-1:0]            req_op,
  input  logic [DATA_W-1:0]          req_a,
  input  logic [DATA_W-1:0]          req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [RES_W-1:0]           rsp_res,
  output logic                       rsp_zero,
  output logic                       rsp_err,
  output logic [NUM_UNITS-1:0]       unit_start,
  output logic [DATA_W-1:0]          unit_a,
  output logic [DATA_W-1:0]          unit_b,
  input  logic [RES_W*NUM_UNITS-1:0] unit_res,
  input  logic [NUM_UNITS-1:0]       unit_done,
  output logic [1:0]                 dbg_state
);

  disp_state_t     state_q, state_d;
  logic [OP_W-1:0] op_q;

  logic             accept;
  logic             rsp_load;
  logic [RES_W-1:0] res_d;
  logic             zero_d;
  logic             err_d;
  logic             wd_clear;
  logic             wd_en;
  logic             wd_expired;

  logic             done_sel;
  logic [RES_W-1:0] res_sel;

  alu_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_en),
    .expired (wd_expired)
  );

  // Only the addressed unit's done/result are visible; stray done pulses
  // from other units never reach the FSM.
  always_comb begin
    done_sel = 1'b0;
    res_sel  = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (int'(op_q) == i) begin
        done_sel = unit_done[i];
        res_sel  = unit_res[RES_W*i +: RES_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    rsp_load = 1'b0;
    res_d    = '0;
    zero_d   = 1'b0;
    err_d    = 1'b0;
    wd_clear = 1'b0;
    wd_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (!op_in_range(req_op, NUM_UNITS)) begin
            rsp_load = 1'b1;
            err_d    = 1'b1;
            state_d  = ST_RESP;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        wd_clear = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        wd_en = 1'b1;
        if (done_sel) begin
          rsp_load = 1'b1;
          res_d    = res_sel;
          zero_d   = (res_sel == '0);
          state_d  = ST_RESP;
        end else if (wd_expired) begin
          rsp_load = 1'b1;
          err_d    = 1'b1;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Operands double as the unit broadcast, so they stay put until the next accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q   <= '0;
      unit_a <= '0;
      unit_b <= '0;
    end else if (accept) begin
      op_q   <= req_op;
      unit_a <= req_a;
      unit_b <= req_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_res  <= '0;
      rsp_zero <= 1'b0;
      rsp_err  <= 1'b0;
    end else if (rsp_load) begin
      rsp_res  <= res_d;
      rsp_zero <= zero_d;
      rsp_err  <= err_d;
    end
  end

  always_comb begin
    unit_start = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      unit_start[i] = (state_q == ST_ISSUE) && (int'(op_q) == i);
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign dbg_state = state_q;

endmodule
